// File: rtl/hazard_control_unit_pkg.sv
// Shared types and helpers for the pipeline hazard control unit.
package hazard_control_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } forward_sel_t;

    // Pick the youngest in-flight producer of rs; x0 is never forwarded.
    function automatic forward_sel_t fwd_select(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_MEM;
        end
        if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_control_unit_forwarding_unit.sv
// EX-stage operand forwarding selects; forced to register file while disabled.
module hazard_control_unit_forwarding_unit
    import hazard_control_unit_pkg::*;
(
    input  logic                  en_i,
    input  logic [REG_ADDR_W-1:0] rs1_e_i,
    input  logic [REG_ADDR_W-1:0] rs2_e_i,
    input  logic [REG_ADDR_W-1:0] rd_m_i,
    input  logic                  reg_w_en_m_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    input  logic                  reg_w_en_w_i,
    output logic [1:0]            forward_a_o,
    output logic [1:0]            forward_b_o
);

    // Memory-stage producer beats Writeback-stage producer for each operand
    always_comb begin
        forward_a_o = FWD_RF;
        forward_b_o = FWD_RF;
        if (en_i) begin
            forward_a_o = fwd_select(rs1_e_i, rd_m_i, reg_w_en_m_i, rd_w_i, reg_w_en_w_i);
            forward_b_o = fwd_select(rs2_e_i, rd_m_i, reg_w_en_m_i, rd_w_i, reg_w_en_w_i);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: post-reset fill, memory-wait stalls, load-use and
// control-hazard stall/flush decode, memory watchdog and EX forwarding.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int unsigned FILL_CYCLES = 3,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_ADDR_W-1:0] RS1_D,
    input  logic [REG_ADDR_W-1:0] RS2_D,
    input  logic [REG_ADDR_W-1:0] RS1_E,
    input  logic [REG_ADDR_W-1:0] RS2_E,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic                  REG_W_En_E,
    input  logic [1:0]            Result_Src_Sel_E,
    input  logic                  PC_Src_Sel_E,
    input  logic [REG_ADDR_W-1:0] RD_M,
    input  logic [REG_ADDR_W-1:0] RD_W,
    input  logic                  REG_W_En_M,
    input  logic                  REG_W_En_W,
    input  logic                  MEM_Req_M,
    input  logic                  MEM_Ready_M,
    output logic                  Stall_F,
    output logic                  Stall_D,
    output logic                  Stall_E,
    output logic                  Stall_M,
    output logic                  Flush_D,
    output logic                  Flush_E,
    output logic                  Flush_W,
    output logic [1:0]            Forward_A_E,
    output logic [1:0]            Forward_B_E,
    output logic                  MEM_Timeout
);

    localparam int unsigned FILL_W = $clog2(FILL_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hazard_state_t     state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic              mem_hold;
    logic              decode_en;
    logic              load_use;

    // State, counters and sticky watchdog flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= INIT;
            fill_q    <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state plus Mealy stall/flush decode
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        wait_d    = wait_q;
        mem_hold  = 1'b0;
        decode_en = 1'b0;
        Stall_F   = 1'b0;
        Stall_D   = 1'b0;
        Stall_E   = 1'b0;
        Stall_M   = 1'b0;
        Flush_D   = 1'b0;
        Flush_E   = 1'b0;
        Flush_W   = 1'b0;
        load_use  = REG_W_En_E && (Result_Src_Sel_E == RESULT_SRC_LOAD) &&
                    (RD_E != '0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

        unique case (state_q)
            INIT: begin
                Stall_F = 1'b1;
                Flush_D = 1'b1;
                Flush_E = 1'b1;
                Flush_W = 1'b1;
                if (fill_q == FILL_LAST) begin
                    state_d = RUN;
                    fill_d  = '0;
                end else begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            RUN: begin
                if (MEM_Req_M && !MEM_Ready_M) begin
                    mem_hold = 1'b1;
                    state_d  = MEM_WAIT;
                    wait_d   = WAIT_W'(1);
                end else begin
                    decode_en = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!MEM_Ready_M) begin
                    mem_hold = 1'b1;
                    if (wait_q != WAIT_LAST) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    // Release cycle: pipeline advances, so Execute hazards apply again
                    decode_en = 1'b1;
                    state_d   = RUN;
                    wait_d    = '0;
                end
            end
            default: begin
                state_d = INIT;
                fill_d  = '0;
                wait_d  = '0;
            end
        endcase

        if (mem_hold) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Flush_W = 1'b1;
        end else if (decode_en) begin
            if (PC_Src_Sel_E) begin
                Flush_D = 1'b1;
                Flush_E = 1'b1;
            end else if (load_use) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Flush_E = 1'b1;
            end
        end

        timeout_d = timeout_q | (wait_d == WAIT_LAST);
    end

    assign MEM_Timeout = timeout_q;

    // Operand forwarding, inactive during pipeline fill
    hazard_control_unit_forwarding_unit u_fwd (
        .en_i         (state_q != INIT),
        .rs1_e_i      (RS1_E),
        .rs2_e_i      (RS2_E),
        .rd_m_i       (RD_M),
        .reg_w_en_m_i (REG_W_En_M),
        .rd_w_i       (RD_W),
        .reg_w_en_w_i (REG_W_En_W),
        .forward_a_o  (Forward_A_E),
        .forward_b_o  (Forward_B_E)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed and randomized check of hazard_control_unit against a cycle model.
module tb_hazard_control_unit;

    localparam int FILL = 3;
    localparam int MT   = 16;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       we_e, we_m, we_w, pc_src, mem_req, mem_ready;
    logic [1:0] res_src;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w, mem_timeout;
    logic [1:0] fwd_a, fwd_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: edges seen since reset release, wait cycles so far
    int fill_edges;
    bit m_wait;
    int wait_n;
    bit m_to;

    hazard_control_unit #(.FILL_CYCLES(FILL), .MEM_TIMEOUT(MT)) dut (
        .CLK(clk), .RST(rst_n),
        .RS1_D(rs1_d), .RS2_D(rs2_d), .RS1_E(rs1_e), .RS2_E(rs2_e),
        .RD_E(rd_e), .REG_W_En_E(we_e), .Result_Src_Sel_E(res_src),
        .PC_Src_Sel_E(pc_src), .RD_M(rd_m), .RD_W(rd_w),
        .REG_W_En_M(we_m), .REG_W_En_W(we_w),
        .MEM_Req_M(mem_req), .MEM_Ready_M(mem_ready),
        .Stall_F(stall_f), .Stall_D(stall_d), .Stall_E(stall_e), .Stall_M(stall_m),
        .Flush_D(flush_d), .Flush_E(flush_e), .Flush_W(flush_w),
        .Forward_A_E(fwd_a), .Forward_B_E(fwd_b), .MEM_Timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic bit model_init();
        return (rst_n !== 1'b1) || (fill_edges < FILL);
    endfunction

    function automatic bit model_hold();
        if (model_init()) return 1'b0;
        if (m_wait) return !mem_ready;
        return mem_req && !mem_ready;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (model_init()) return 2'b00;
        if (we_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (we_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Compare every output against the model for the current inputs
    task automatic check_outputs(input string tag);
        bit init_ph, hold, lu, br;
        bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
        init_ph = model_init();
        hold    = model_hold();
        lu = !init_ph && !hold && we_e && res_src == 2'b01 && rd_e != 0 &&
             (rd_e == rs1_d || rd_e == rs2_d);
        br = !init_ph && !hold && pc_src;
        e_sf = init_ph || hold || (lu && !br);
        e_sd = hold || (lu && !br);
        e_se = hold;
        e_sm = hold;
        e_fd = init_ph || br;
        e_fe = init_ph || br || lu;
        e_fw = init_ph || hold;
        cmp($sformatf("%s Stall_F", tag), stall_f, e_sf);
        cmp($sformatf("%s Stall_D", tag), stall_d, e_sd);
        cmp($sformatf("%s Stall_E", tag), stall_e, e_se);
        cmp($sformatf("%s Stall_M", tag), stall_m, e_sm);
        cmp($sformatf("%s Flush_D", tag), flush_d, e_fd);
        cmp($sformatf("%s Flush_E", tag), flush_e, e_fe);
        cmp($sformatf("%s Flush_W", tag), flush_w, e_fw);
        cmp($sformatf("%s Forward_A_E", tag), fwd_a, model_fwd(rs1_e));
        cmp($sformatf("%s Forward_B_E", tag), fwd_b, model_fwd(rs2_e));
        cmp($sformatf("%s MEM_Timeout", tag), mem_timeout, (rst_n === 1'b1) ? m_to : 1'b0);
    endtask

    task automatic sample(input string tag);
        #1;
        check_outputs(tag);
    endtask

    // Advance one clock and update the model with the inputs held across the edge
    task automatic advance();
        bit hold, init_ph;
        hold    = model_hold();
        init_ph = model_init();
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            fill_edges = 0; m_wait = 0; wait_n = 0; m_to = 0;
        end else if (init_ph) begin
            fill_edges++;
        end else if (hold) begin
            wait_n++;
            m_wait = 1'b1;
            if (wait_n >= MT - 1) m_to = 1'b1;
        end else begin
            m_wait = 1'b0;
            wait_n = 0;
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        sample(tag);
        advance();
    endtask

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        we_e = 0; we_m = 0; we_w = 0; pc_src = 0; mem_req = 0; mem_ready = 0;
        res_src = 2'b00;
    endtask

    initial begin
        fill_edges = 0; m_wait = 0; wait_n = 0; m_to = 0;
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        step("reset");
        // Forwarding pattern held during reset must stay at register file
        rd_m = 7; we_m = 1; rs1_e = 7;
        step("reset_fwd");
        clear_inputs();

        // Pipeline fill after reset release
        rst_n = 1'b1;
        for (int k = 0; k < FILL + 2; k++) step($sformatf("fill%0d", k));

        // Load-use, then the same pattern on x0
        res_src = 2'b01; we_e = 1; rd_e = 5; rs1_d = 5;
        sample("load_use");
        cmp("load_use direct Stall_D", stall_d, 1'b1);
        advance();
        rd_e = 0; rs1_d = 0;
        step("load_use_x0");
        clear_inputs();
        step("idle");

        // Taken branch, and branch coinciding with load-use
        pc_src = 1;
        step("branch");
        res_src = 2'b01; we_e = 1; rd_e = 9; rs2_d = 9;
        step("branch_and_load");
        clear_inputs();
        step("idle2");

        // Four wait cycles with a branch pending, released on the fifth
        mem_req = 1; mem_ready = 0; pc_src = 1;
        for (int k = 1; k <= 4; k++) step($sformatf("memwait%0d", k));
        mem_ready = 1;
        sample("mem_release");
        cmp("mem_release direct Stall_M", stall_m, 1'b0);
        advance();
        clear_inputs();
        step("idle3");

        // Watchdog: ready never arrives
        mem_req = 1; mem_ready = 0;
        for (int k = 1; k <= MT + 3; k++) begin
            sample($sformatf("timeout%0d", k));
            cmp($sformatf("timeout%0d direct", k), mem_timeout, (k >= MT) ? 1'b1 : 1'b0);
            advance();
        end
        // Asynchronous reset in the middle of a cycle
        #3 rst_n = 1'b0;
        #1 check_outputs("async_rst");
        cmp("async_rst direct MEM_Timeout", mem_timeout, 1'b0);
        @(negedge clk);
        fill_edges = 0; m_wait = 0; wait_n = 0; m_to = 0;
        clear_inputs();
        step("in_reset");
        rst_n = 1'b1;
        for (int k = 0; k < FILL + 1; k++) step($sformatf("refill%0d", k));

        // Forwarding priority
        rd_m = 7; rd_w = 7; we_m = 1; we_w = 1; rs1_e = 7; rs2_e = 3;
        sample("fwd_mem");
        cmp("fwd_mem direct A", fwd_a, 2'b10);
        cmp("fwd_mem direct B", fwd_b, 2'b00);
        advance();
        rd_m = 0;
        sample("fwd_wb");
        cmp("fwd_wb direct A", fwd_a, 2'b01);
        advance();
        clear_inputs();

        // Randomized traffic with narrow register ranges to provoke hazards
        for (int k = 0; k < 600; k++) begin
            rst_n     = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            rs1_d     = 5'($urandom_range(0, 3));
            rs2_d     = 5'($urandom_range(0, 3));
            rs1_e     = 5'($urandom_range(0, 3));
            rs2_e     = 5'($urandom_range(0, 3));
            rd_e      = 5'($urandom_range(0, 3));
            rd_m      = 5'($urandom_range(0, 3));
            rd_w      = 5'($urandom_range(0, 3));
            we_e      = 1'($urandom);
            we_m      = 1'($urandom);
            we_w      = 1'($urandom);
            res_src   = 2'($urandom);
            pc_src    = ($urandom_range(0, 5) == 0);
            mem_req   = ($urandom_range(0, 2) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            step($sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
